// File: rtl/thread_scheduler.sv
// thread_scheduler: lifecycle controller and round-robin issue scheduler for
// the hardware threads of the barrel core.
//   clk, rst_n          clock, asynchronous active-low reset
//   sched_en            global issue enable (state tracking continues when 0)
//   spawn_req/trd/arg   start a FREE thread, argument goes to its r4
//   spawn_ack/err       1-cycle accept / reject pulses
//   kill_req/trd        return a thread to FREE
//   stall_req/trd/cycles park a RUN thread for stall_cycles cycles
//   init/init_trd/init_data  regfile init strobe, target and data
//   issue_vld/issue_trd thread selected for issue this cycle
//   trd_active          bit i set while thread i is not FREE
module thread_scheduler #(
  parameter int unsigned NUM_TRD = 8,
  parameter int unsigned TRD_W   = 3,
  parameter int unsigned STALL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sched_en,
  input  logic               spawn_req,
  input  logic [TRD_W-1:0]   spawn_trd,
  input  logic [31:0]        spawn_arg,
  output logic               spawn_ack,
  output logic               spawn_err,
  input  logic               kill_req,
  input  logic [TRD_W-1:0]   kill_trd,
  input  logic               stall_req,
  input  logic [TRD_W-1:0]   stall_trd,
  input  logic [STALL_W-1:0] stall_cycles,
  output logic               init,
  output logic [TRD_W-1:0]   init_trd,
  output logic [31:0]        init_data,
  output logic               issue_vld,
  output logic [TRD_W-1:0]   issue_trd,
  output logic [NUM_TRD-1:0] trd_active
);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  logic [NUM_TRD-1:0][1:0]         st_q, st_d;
  logic [NUM_TRD-1:0][STALL_W-1:0] cnt_q, cnt_d;
  logic [TRD_W-1:0]                ptr_q, ptr_d;

  logic               spawn_ack_d, spawn_err_d, init_d, issue_vld_d;
  logic [TRD_W-1:0]   init_trd_d, issue_trd_d;
  logic [31:0]        init_data_d;
  logic [NUM_TRD-1:0] trd_active_d;

  logic               found;
  logic [TRD_W-1:0]   idx, pick;

  // Next-state: spawn/kill/stall handling, per-thread FSM, round-robin pick
  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    spawn_ack_d  = 1'b0;
    spawn_err_d  = 1'b0;
    init_d       = 1'b0;
    init_trd_d   = init_trd;
    init_data_d  = init_data;
    issue_vld_d  = 1'b0;
    issue_trd_d  = issue_trd;
    trd_active_d = '0;
    found        = 1'b0;
    idx          = '0;
    pick         = '0;

    // Kill to the same FREE thread silently wins; a busy target is always an error
    if (spawn_req) begin
      if (st_q[spawn_trd] != ST_FREE) begin
        spawn_err_d = 1'b1;
      end else if (!(kill_req && (kill_trd == spawn_trd))) begin
        spawn_ack_d = 1'b1;
        init_d      = 1'b1;
        init_trd_d  = spawn_trd;
        init_data_d = spawn_arg;
      end
    end

    for (int unsigned i = 0; i < NUM_TRD; i++) begin
      case (st_q[i])
        ST_FREE: if (spawn_ack_d && (spawn_trd == TRD_W'(i))) st_d[i] = ST_INIT;
        ST_INIT: st_d[i] = ST_RUN;
        ST_RUN: begin
          if (stall_req && (stall_trd == TRD_W'(i)) && (stall_cycles != '0)) begin
            st_d[i]  = ST_WAIT;
            cnt_d[i] = stall_cycles;
          end
        end
        ST_WAIT: begin
          // Leave on the 1->0 edge so the thread misses exactly stall_cycles picks
          cnt_d[i] = cnt_q[i] - STALL_W'(1);
          if (cnt_q[i] == STALL_W'(1)) st_d[i] = ST_RUN;
        end
        default: st_d[i] = ST_FREE;
      endcase
      if (kill_req && (kill_trd == TRD_W'(i))) begin
        st_d[i]  = ST_FREE;
        cnt_d[i] = '0;
      end
      trd_active_d[i] = (st_d[i] != ST_FREE);
    end

    // Search ptr+1 .. ptr+NUM_TRD; thread-id arithmetic wraps naturally
    for (int unsigned k = 1; k <= NUM_TRD; k++) begin
      idx = ptr_q + TRD_W'(k);
      if (!found && (st_q[idx] == ST_RUN)) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    if (sched_en && found) begin
      issue_vld_d = 1'b1;
      issue_trd_d = pick;
      ptr_d       = pick;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= '0;
      cnt_q      <= '0;
      ptr_q      <= TRD_W'(NUM_TRD - 1);
      spawn_ack  <= 1'b0;
      spawn_err  <= 1'b0;
      init       <= 1'b0;
      init_trd   <= '0;
      init_data  <= '0;
      issue_vld  <= 1'b0;
      issue_trd  <= '0;
      trd_active <= '0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      spawn_ack  <= spawn_ack_d;
      spawn_err  <= spawn_err_d;
      init       <= init_d;
      init_trd   <= init_trd_d;
      init_data  <= init_data_d;
      issue_vld  <= issue_vld_d;
      issue_trd  <= issue_trd_d;
      trd_active <= trd_active_d;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed testbench for thread_scheduler: a spawn/issue vector table plus
// hand-written sequences for stall, spawn errors, kill, sched_en and reset.
module tb_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en;
  logic        spawn_req;
  logic [2:0]  spawn_trd;
  logic [31:0] spawn_arg;
  logic        spawn_ack, spawn_err;
  logic        kill_req;
  logic [2:0]  kill_trd;
  logic        stall_req;
  logic [2:0]  stall_trd;
  logic [3:0]  stall_cycles;
  logic        init;
  logic [2:0]  init_trd;
  logic [31:0] init_data;
  logic        issue_vld;
  logic [2:0]  issue_trd;
  logic [7:0]  trd_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  thread_scheduler dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .spawn_req(spawn_req), .spawn_trd(spawn_trd), .spawn_arg(spawn_arg),
    .spawn_ack(spawn_ack), .spawn_err(spawn_err),
    .kill_req(kill_req), .kill_trd(kill_trd),
    .stall_req(stall_req), .stall_trd(stall_trd), .stall_cycles(stall_cycles),
    .init(init), .init_trd(init_trd), .init_data(init_data),
    .issue_vld(issue_vld), .issue_trd(issue_trd), .trd_active(trd_active)
  );

  typedef struct {
    logic        req;
    logic [2:0]  trd;
    logic [31:0] arg;
    logic        ack;
    logic        err;
    logic        ini;
    logic [2:0]  itrd;
    logic [31:0] idata;
    logic        vld;
    logic [2:0]  itr;
    logic [7:0]  act;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    spawn_req = 1'b0; spawn_trd = '0; spawn_arg = '0;
    kill_req = 1'b0; kill_trd = '0;
    stall_req = 1'b0; stall_trd = '0; stall_cycles = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ack"},    32'(spawn_ack), 32'd0);
    chk({nm, ".err"},    32'(spawn_err), 32'd0);
    chk({nm, ".init"},   32'(init), 32'd0);
    chk({nm, ".itrd"},   32'(init_trd), 32'd0);
    chk({nm, ".idata"},  init_data, 32'd0);
    chk({nm, ".vld"},    32'(issue_vld), 32'd0);
    chk({nm, ".trd"},    32'(issue_trd), 32'd0);
    chk({nm, ".active"}, 32'(trd_active), 32'd0);
  endtask

  task automatic chk_issue(input string nm, input logic [2:0] t);
    chk({nm, ".vld"}, 32'(issue_vld), 32'd1);
    chk({nm, ".trd"}, 32'(issue_trd), 32'(t));
  endtask

  initial begin
    logic [2:0] seq_stall [6];
    // spawn 0 then 2, 5; issue starts the 3rd cycle after a request
    tbl[0]  = '{1'b1, 3'd0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b0, 3'd0, 8'h01};
    tbl[1]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b0, 3'd0, 8'h01};
    tbl[2]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b1, 3'd0, 8'h01};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 32'hDEADBEEF, 1'b1, 3'd0, 8'h01};
    tbl[4]  = '{1'b1, 3'd2, 32'h2,        1'b1, 1'b0, 1'b1, 3'd2, 32'h2,        1'b1, 3'd0, 8'h05};
    tbl[5]  = '{1'b1, 3'd5, 32'h5,        1'b1, 1'b0, 1'b1, 3'd5, 32'h5,        1'b1, 3'd0, 8'h25};
    tbl[6]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd2, 8'h25};
    tbl[7]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd5, 8'h25};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd0, 8'h25};
    tbl[9]  = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd2, 8'h25};
    tbl[10] = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd5, 8'h25};
    tbl[11] = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd0, 8'h25};
    tbl[12] = '{1'b0, 3'd0, 32'h0,        1'b0, 1'b0, 1'b0, 3'd5, 32'h5,        1'b1, 3'd2, 8'h25};

    rst_n = 1'b0;
    sched_en = 1'b1;
    clr_in();
    #3;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      spawn_req = tbl[v].req;
      spawn_trd = tbl[v].trd;
      spawn_arg = tbl[v].arg;
      tick();
      chk($sformatf("vec%0d.ack", v),    32'(spawn_ack), 32'(tbl[v].ack));
      chk($sformatf("vec%0d.err", v),    32'(spawn_err), 32'(tbl[v].err));
      chk($sformatf("vec%0d.init", v),   32'(init), 32'(tbl[v].ini));
      chk($sformatf("vec%0d.itrd", v),   32'(init_trd), 32'(tbl[v].itrd));
      chk($sformatf("vec%0d.idata", v),  init_data, tbl[v].idata);
      chk($sformatf("vec%0d.vld", v),    32'(issue_vld), 32'(tbl[v].vld));
      chk($sformatf("vec%0d.trd", v),    32'(issue_trd), 32'(tbl[v].itr));
      chk($sformatf("vec%0d.active", v), 32'(trd_active), 32'(tbl[v].act));
    end
    clr_in();

    // Spawn to a RUN thread is rejected without side effects
    spawn_req = 1'b1; spawn_trd = 3'd2; spawn_arg = 32'h1234;
    tick(); clr_in();
    chk("err_run.err",  32'(spawn_err), 32'd1);
    chk("err_run.ack",  32'(spawn_ack), 32'd0);
    chk("err_run.init", 32'(init), 32'd0);
    chk_issue("err_run", 3'd5);

    // Kill + spawn to a busy thread: error, and the thread goes FREE
    kill_req = 1'b1; kill_trd = 3'd5; spawn_req = 1'b1; spawn_trd = 3'd5;
    tick(); clr_in();
    chk("kill_spawn_busy.err",    32'(spawn_err), 32'd1);
    chk("kill_spawn_busy.ack",    32'(spawn_ack), 32'd0);
    chk("kill_spawn_busy.active", 32'(trd_active), 32'h05);
    chk_issue("kill_spawn_busy", 3'd0);

    // Kill + spawn to a FREE thread: neither pulse, thread stays FREE
    kill_req = 1'b1; kill_trd = 3'd3; spawn_req = 1'b1; spawn_trd = 3'd3;
    tick(); clr_in();
    chk("kill_spawn_free.err",    32'(spawn_err), 32'd0);
    chk("kill_spawn_free.ack",    32'(spawn_ack), 32'd0);
    chk("kill_spawn_free.init",   32'(init), 32'd0);
    chk("kill_spawn_free.active", 32'(trd_active), 32'h05);
    chk_issue("kill_spawn_free", 3'd2);

    // Stall thread 2 for 3 cycles; a second stall while waiting must not reload
    seq_stall[0] = 3'd0; seq_stall[1] = 3'd0; seq_stall[2] = 3'd0;
    seq_stall[3] = 3'd0; seq_stall[4] = 3'd2; seq_stall[5] = 3'd0;
    stall_req = 1'b1; stall_trd = 3'd2; stall_cycles = 4'd3;
    for (int s = 0; s < 6; s++) begin
      tick(); clr_in();
      chk_issue($sformatf("stall%0d", s), seq_stall[s]);
      if (s == 1) begin
        stall_req = 1'b1; stall_trd = 3'd2; stall_cycles = 4'd7;
      end
    end
    chk("stall.active", 32'(trd_active), 32'h05);

    // Bring thread 5 back, then freeze issue for 4 cycles (last issued = 2)
    spawn_req = 1'b1; spawn_trd = 3'd5; spawn_arg = 32'h55;
    tick(); clr_in();
    chk("respawn5.ack", 32'(spawn_ack), 32'd1);
    chk_issue("respawn5", 3'd2);
    tick();
    chk_issue("respawn5_init", 3'd0);
    tick();
    chk_issue("respawn5_run", 3'd2);
    sched_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk($sformatf("frozen%0d.vld", s), 32'(issue_vld), 32'd0);
      chk($sformatf("frozen%0d.trd", s), 32'(issue_trd), 32'd2);
    end
    sched_en = 1'b1;
    stall_req = 1'b1; stall_trd = 3'd0; stall_cycles = 4'd0;
    tick(); clr_in();
    chk_issue("resume0", 3'd5);
    tick();
    chk_issue("resume1", 3'd0);

    // Thread 1 into WAIT with counter 5, then reset during an init pulse
    spawn_req = 1'b1; spawn_trd = 3'd1; spawn_arg = 32'h11;
    tick(); clr_in();
    tick();
    stall_req = 1'b1; stall_trd = 3'd1; stall_cycles = 4'd6;
    tick(); clr_in();
    spawn_req = 1'b1; spawn_trd = 3'd3; spawn_arg = 32'h33;
    tick(); clr_in();
    chk("pre_reset.init",   32'(init), 32'd1);
    chk("pre_reset.active", 32'(trd_active), 32'h2F);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      tick();
      chk($sformatf("post_reset%0d.vld", s), 32'(issue_vld), 32'd0);
      chk($sformatf("post_reset%0d.active", s), 32'(trd_active), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
